// File: rtl/tcdm_prio_scheduler.sv
// tcdm_prio_scheduler: picks core-vs-HWPE priority for the TCDM interconnect
// using a fixed, weighted round-robin or starvation-guard policy.
`default_nettype none

module tcdm_prio_scheduler #(
    parameter int NB_CORES  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [NB_CORES-1:0]  core_req_i,
    input  logic [NB_CORES-1:0]  core_gnt_i,
    input  logic                 hwpe_req_i,
    input  logic                 hwpe_gnt_i,
    input  logic [1:0]           cfg_mode_i,
    input  logic [CNT_WIDTH-1:0] cfg_core_weight_i,
    input  logic [CNT_WIDTH-1:0] cfg_hwpe_weight_i,
    input  logic [CNT_WIDTH-1:0] cfg_starve_thr_i,
    output logic                 invert_prio_o,
    output logic [CNT_WIDTH-1:0] hwpe_stall_cnt_o,
    output logic [CNT_WIDTH-1:0] core_max_stall_o
);

    typedef enum logic [0:0] {
        CORE_PRIO = 1'b0,
        HWPE_PRIO = 1'b1
    } state_t;

    localparam logic [1:0] MODE_CORE   = 2'd0;
    localparam logic [1:0] MODE_HWPE   = 2'd1;
    localparam logic [1:0] MODE_WRR    = 2'd2;
    localparam logic [1:0] MODE_STARVE = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] slot_q, slot_d;
    logic [CNT_WIDTH-1:0] hstall_q, hstall_d;
    logic [CNT_WIDTH-1:0] crun_q, crun_d;
    logic [CNT_WIDTH-1:0] cmax_q, cmax_d;
    logic [1:0]           mode_q;
    logic                 invert_q;

    logic                 core_act, core_win, core_stall;
    logic                 hwpe_win, hwpe_stall;
    logic                 mode_changed;
    logic [CNT_WIDTH-1:0] core_last, hwpe_last, thr_eff;

    assign core_act     = |core_req_i;
    assign core_win     = |(core_req_i & core_gnt_i);
    assign core_stall   = core_act & ~core_win;
    assign hwpe_win     = hwpe_req_i & hwpe_gnt_i;
    assign hwpe_stall   = hwpe_req_i & ~hwpe_gnt_i;
    assign mode_changed = (cfg_mode_i != mode_q);

    // Zero weight/threshold behaves as one; slot index of the last cycle is weight-1.
    assign core_last = (cfg_core_weight_i == CNT_ZERO) ? CNT_ZERO : cfg_core_weight_i - CNT_ONE;
    assign hwpe_last = (cfg_hwpe_weight_i == CNT_ZERO) ? CNT_ZERO : cfg_hwpe_weight_i - CNT_ONE;
    assign thr_eff   = (cfg_starve_thr_i == CNT_ZERO) ? CNT_ONE : cfg_starve_thr_i;

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        hstall_d = hwpe_stall ? ((hstall_q == CNT_MAX) ? CNT_MAX : hstall_q + CNT_ONE) : CNT_ZERO;
        crun_d   = core_stall ? ((crun_q == CNT_MAX) ? CNT_MAX : crun_q + CNT_ONE) : CNT_ZERO;
        cmax_d   = (crun_d > cmax_q) ? crun_d : cmax_q;

        if (mode_changed) begin
            state_d  = (cfg_mode_i == MODE_HWPE) ? HWPE_PRIO : CORE_PRIO;
            slot_d   = CNT_ZERO;
            hstall_d = CNT_ZERO;
        end else begin
            case (cfg_mode_i)
                MODE_CORE: begin
                    state_d = CORE_PRIO;
                    slot_d  = CNT_ZERO;
                end
                MODE_HWPE: begin
                    state_d = HWPE_PRIO;
                    slot_d  = CNT_ZERO;
                end
                MODE_WRR: begin
                    if (state_q == CORE_PRIO) begin
                        if (core_win) begin
                            if (slot_q >= core_last) begin
                                state_d = HWPE_PRIO;
                                slot_d  = CNT_ZERO;
                            end else begin
                                slot_d  = slot_q + CNT_ONE;
                            end
                        end else if (!core_act && hwpe_req_i) begin
                            state_d = HWPE_PRIO;
                            slot_d  = CNT_ZERO;
                        end
                    end else begin
                        if (hwpe_win) begin
                            if (slot_q >= hwpe_last) begin
                                state_d = CORE_PRIO;
                                slot_d  = CNT_ZERO;
                            end else begin
                                slot_d  = slot_q + CNT_ONE;
                            end
                        end else if (!hwpe_req_i && core_act) begin
                            state_d = CORE_PRIO;
                            slot_d  = CNT_ZERO;
                        end
                    end
                end
                MODE_STARVE: begin
                    if (state_q == CORE_PRIO) begin
                        slot_d = CNT_ZERO;
                        if (hwpe_stall && (hstall_q == thr_eff)) begin
                            state_d  = HWPE_PRIO;
                            hstall_d = CNT_ZERO;
                        end
                    end else begin
                        if (!hwpe_req_i) begin
                            state_d = CORE_PRIO;
                            slot_d  = CNT_ZERO;
                        end else if (hwpe_win) begin
                            if (slot_q >= hwpe_last) begin
                                state_d = CORE_PRIO;
                                slot_d  = CNT_ZERO;
                            end else begin
                                slot_d  = slot_q + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = CORE_PRIO;
                    slot_d  = CNT_ZERO;
                end
            endcase
        end
    end

    // Mode register follows the config during reset so leaving reset is not seen as a mode change.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q  <= CORE_PRIO;
            slot_q   <= CNT_ZERO;
            hstall_q <= CNT_ZERO;
            crun_q   <= CNT_ZERO;
            cmax_q   <= CNT_ZERO;
            mode_q   <= cfg_mode_i;
            invert_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            hstall_q <= hstall_d;
            crun_q   <= crun_d;
            cmax_q   <= cmax_d;
            mode_q   <= cfg_mode_i;
            invert_q <= (state_q == HWPE_PRIO);
        end
    end

    assign invert_prio_o    = invert_q;
    assign hwpe_stall_cnt_o = hstall_q;
    assign core_max_stall_o = cmax_q;

endmodule

`default_nettype wire

// File: doc/tcdm_prio_scheduler.md
Name: tcdm_prio_scheduler

Overview:
- Sequences the priority between the core-side logarithmic branch and the HWPE branch of the cluster TCDM heterogeneous interconnect.
- Observes per-cycle request/grant activity on both branches.
- Drives a registered priority-inversion control (the invert_prio field of the interconnect control struct), chosen by programmable policy: fixed, weighted round-robin, or starvation guard.
- Sits beside the cluster interconnect wrapper; configured from cluster peripheral registers.

Parameters:
- NB_CORES, 8, number of core TCDM request ports observed
- CNT_WIDTH, 8, width of weight, threshold and stall counters

Ports:
- clk_i  in  1  cluster clock
- rst_ni  in  1  synchronous active-low reset
- clear_i  in  1  synchronous clear; same effect as reset, one cycle
- core_req_i  in  NB_CORES  per-core TCDM request
- core_gnt_i  in  NB_CORES  per-core TCDM grant
- hwpe_req_i  in  1  HWPE branch request
- hwpe_gnt_i  in  1  HWPE branch grant
- cfg_mode_i  in  2  0=fixed core prio, 1=fixed HWPE prio, 2=weighted RR, 3=starvation guard
- cfg_core_weight_i  in  CNT_WIDTH  core-priority slot length, in granted cycles
- cfg_hwpe_weight_i  in  CNT_WIDTH  HWPE-priority slot length, in granted cycles
- cfg_starve_thr_i  in  CNT_WIDTH  consecutive HWPE stall cycles that trigger a switch (mode 3)
- invert_prio_o  out  1  1 = HWPE branch has priority
- hwpe_stall_cnt_o  out  CNT_WIDTH  current consecutive HWPE stall count
- core_max_stall_o  out  CNT_WIDTH  saturating maximum of consecutive core-stall cycles since reset/clear

Behaviour:
- Reset: synchronous, sampled on rising clk_i while rst_ni=0.
  - State CORE_PRIO; all counters 0.
  - invert_prio_o=0, hwpe_stall_cnt_o=0, core_max_stall_o=0.
  - clear_i=1 has the identical effect; rst_ni has precedence.
- Derived per-cycle signals:
  - core_act = |core_req_i
  - core_win = |(core_req_i & core_gnt_i)
  - core_stall = core_act & ~core_win
  - hwpe_stall = hwpe_req_i & ~hwpe_gnt_i
- Weights: a weight of 0 is treated as 1.
- Output timing: invert_prio_o is a registered decode of state (HWPE_PRIO -> 1); one cycle latency from any transition decision.
- FSM states: CORE_PRIO, HWPE_PRIO. slot_cnt counts cycles with a win by the favoured side and resets to 0 on every state change.
- Mode 0: forced CORE_PRIO.
- Mode 1: forced HWPE_PRIO.
- Mode 2 (weighted RR):
  - CORE_PRIO -> HWPE_PRIO when slot_cnt reaches core_weight-1 and core_win is set in that cycle.
  - Also switches when ~core_act & hwpe_req_i (work-conserving).
  - HWPE_PRIO transitions symmetrically, using hwpe_weight, hwpe_gnt_i and core_act.
  - Neither side requesting: hold state and slot_cnt.
- Mode 3 (starvation guard):
  - Default state CORE_PRIO.
  - hwpe_stall_cnt increments (saturating at all-ones) on every hwpe_stall cycle and resets to 0 on any cycle without hwpe_stall.
  - When hwpe_stall_cnt == cfg_starve_thr_i in a hwpe_stall cycle: go to HWPE_PRIO, clear hwpe_stall_cnt.
  - Threshold 0 behaves as 1.
  - HWPE_PRIO -> CORE_PRIO after hwpe_weight HWPE-granted cycles, or immediately when ~hwpe_req_i.
- hwpe_stall_cnt is maintained in all modes but only acts in mode 3.
- core_max_stall:
  - Run counter increments on core_stall, resets otherwise.
  - core_max_stall_o = max(previous value, run count), saturating at 2^CNT_WIDTH-1.
- Mode change (cfg_mode_i differs from the previous cycle's registered value):
  - Next state is the new mode's default: CORE_PRIO for modes 0, 2, 3; HWPE_PRIO for mode 1.
  - slot_cnt and hwpe_stall_cnt are cleared.
  - core_max_stall is kept.
- Weight or threshold changes mid-slot take effect at the next comparison; no clear.
- Simultaneous slot expiry and favoured side going idle: a single transition.

Test Plan:
- Reset with core_req_i=8'hFF, hwpe_req_i=1 held -> invert_prio_o=0, counters 0; after release in mode 0, invert_prio_o stays 0.
- Mode 2, core_weight=3, hwpe_weight=2, all requests always granted -> invert_prio_o pattern 0,0,0,1,1 repeating, starting one cycle after release.
- Mode 2, only hwpe_req_i=1, core_req_i=0 -> invert_prio_o=1 two cycles after the first request cycle and remains 1.
- Mode 3, thr=4, hwpe_req_i=1, hwpe_gnt_i=0 for 5 cycles -> hwpe_stall_cnt_o counts 1..4; then invert_prio_o=1; after 2 HWPE grants with hwpe_weight=2 -> back to 0.
- core_req_i=1 with core_gnt_i=0 for 300 cycles, CNT_WIDTH=8 -> core_max_stall_o saturates at 255; clear_i pulse -> 0.
- Mode 2 in HWPE_PRIO, switch cfg_mode_i to 0 -> invert_prio_o=0 within 2 cycles; rst_ni low mid-slot -> 0 on the next cycle.
